// File: rtl/dds_pkg.sv
// dds_pkg: shared widths and state/direction types for the DDS sweep and modulation controllers.
package dds_pkg;
  localparam int KW_DEF = 32;
  localparam int PW_DEF = 11;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;
  typedef enum logic {UP, DOWN} dir_t;
endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// dds_sweep_ctrl_if: sweep configuration handshake; cfg_tri exists only with DDS_SWEEP_TRIANGLE_EN.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [KW-1:0] cfg_start_k;
  logic [KW-1:0] cfg_stop_k;
  logic [KW-1:0] cfg_step_k;
  logic [DW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_phase;
  logic          cfg_loop;
`ifdef DDS_SWEEP_TRIANGLE_EN
  logic          cfg_tri;
  modport master (output cfg_valid, cfg_start_k, cfg_stop_k, cfg_step_k, cfg_dwell, cfg_phase, cfg_loop, cfg_tri, input cfg_ready);
  modport slave (input cfg_valid, cfg_start_k, cfg_stop_k, cfg_step_k, cfg_dwell, cfg_phase, cfg_loop, cfg_tri, output cfg_ready);
`else
  modport master (output cfg_valid, cfg_start_k, cfg_stop_k, cfg_step_k, cfg_dwell, cfg_phase, cfg_loop, input cfg_ready);
  modport slave (input cfg_valid, cfg_start_k, cfg_stop_k, cfg_step_k, cfg_dwell, cfg_phase, cfg_loop, output cfg_ready);
`endif
endinterface

// File: rtl/dds_dwell_timer.sv
// dds_dwell_timer: loadable one-shot down-counter; expire pulses when the loaded count has elapsed.
module dds_dwell_timer #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_val,
  output logic          expire
);
  logic [DW-1:0] cnt;
  logic          run;
  assign expire = run && cnt == '0;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= load_val;
      run <= 1'b1;
    end else if (expire)
      run <= 1'b0;
    else if (run)
      cnt <= cnt - 1'b1;
endmodule

// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl: linear K sweep sequencer for the DDS core; DDS_SWEEP_TRIANGLE_EN adds an up/down triangle sweep.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int KW = KW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  dds_sweep_ctrl_if.slave cfg,
  input  logic           abort,
  output logic [KW-1:0]  k_out,
  output logic [PW-1:0]  p_out,
  output logic           k_valid,
  output logic           busy,
  output logic           sweep_done
);
  state_t        state_q, state_d, cur;
  dir_t          dir_q, dir_d;
  logic [KW-1:0] start_q, stop_q, step_q, k_d, up_k, dn_k;
  logic [DW-1:0] dwell_q;
  logic          loop_q, tri_q, accept, load, expire, tick, degen, at_top, at_end, turn;
  logic          kv_d, busy_d, done_d;
  logic [KW:0]   nxt_up, nxt_dn;
  assign cfg.cfg_ready = state_q == IDLE;
  assign accept = cfg.cfg_valid && state_q == IDLE;
  assign tick = state_q == DWELL && expire;
  assign nxt_up = {1'b0, k_out} + {1'b0, step_q};
  assign nxt_dn = {1'b0, k_out} - {1'b0, step_q};
  assign up_k = nxt_up >= {1'b0, stop_q} ? stop_q : nxt_up[KW-1:0];
  assign dn_k = (nxt_dn[KW] || nxt_dn[KW-1:0] <= start_q) ? start_q : nxt_dn[KW-1:0];
  assign degen = step_q == '0 || start_q >= stop_q;
  assign at_top = k_out >= stop_q;
  assign at_end = degen || (dir_q == DOWN ? k_out <= start_q : at_top && !tri_q);
  assign turn = !degen && dir_q == UP && tri_q && at_top;
  assign cur = tick && at_end ? DONE : state_q;
  dds_dwell_timer #(.DW(DW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (accept ? cfg.cfg_dwell : dwell_q),
    .expire   (expire)
  );
  // abort outranks both the per-point step and the loop wrap
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    k_d = k_out;
    kv_d = 1'b0;
    busy_d = busy;
    done_d = 1'b0;
    load = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      dir_d = UP;
      k_d = '0;
      kv_d = 1'b1;
      busy_d = 1'b0;
    end else
      case (cur)
        IDLE: if (accept) begin
          state_d = DWELL;
          dir_d = UP;
          k_d = cfg.cfg_start_k;
          kv_d = 1'b1;
          busy_d = 1'b1;
          load = 1'b1;
        end
        DWELL: if (tick) begin
          k_d = (turn || dir_q == DOWN) ? dn_k : up_k;
          dir_d = turn ? DOWN : dir_q;
          kv_d = 1'b1;
          load = 1'b1;
        end
        DONE: begin
          done_d = 1'b1;
          dir_d = UP;
          state_d = loop_q ? DWELL : IDLE;
          busy_d = loop_q;
          k_d = loop_q ? start_q : k_out;
          kv_d = loop_q;
          load = loop_q;
        end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      dir_q <= UP;
      k_out <= '0;
      p_out <= '0;
      k_valid <= 1'b0;
      busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      k_out <= k_d;
      k_valid <= kv_d;
      busy <= busy_d;
      sweep_done <= done_d;
      if (accept) p_out <= cfg.cfg_phase;
    end
  always_ff @(posedge clk)
    if (rst) begin
      start_q <= '0;
      stop_q <= '0;
      step_q <= '0;
      dwell_q <= '0;
      loop_q <= 1'b0;
    end else if (accept) begin
      start_q <= cfg.cfg_start_k;
      stop_q <= cfg.cfg_stop_k;
      step_q <= cfg.cfg_step_k;
      dwell_q <= cfg.cfg_dwell;
      loop_q <= cfg.cfg_loop;
    end
`ifdef DDS_SWEEP_TRIANGLE_EN
  always_ff @(posedge clk)
    if (rst) tri_q <= 1'b0;
    else if (accept) tri_q <= cfg.cfg_tri;
`else
  assign tri_q = 1'b0;
`endif
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb_dds_sweep_ctrl: table-driven sweeps plus hand sequences for loop, abort and mid-sweep reset.
module tb_dds_sweep_ctrl;
  typedef struct {
    logic [31:0]      start, stop, step;
    logic [15:0]      dwell;
    logic [10:0]      phase;
    logic             tri_m;
    int               npts;
    logic [7:0][31:0] pts;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, abort = 1'b0;
  logic [31:0] k_out;
  logic [10:0] p_out;
  logic        k_valid, busy, sweep_done;
  int          checks = 0, errors = 0;
  vec_t        tbl[6];
  vec_t        v2, vt;
  logic [31:0] lseq[4] = '{32'd100, 32'd110, 32'd120, 32'd130};

  dds_sweep_ctrl_if bus ();
  dds_sweep_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg        (bus),
    .abort      (abort),
    .k_out      (k_out),
    .p_out      (p_out),
    .k_valid    (k_valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] a, b, c, input logic [15:0] d, input logic [10:0] ph,
                              input logic t, input int n, input logic [31:0] p0, p1, p2, p3, p4, p5, p6);
    vec_t v;
    v.start = a; v.stop = b; v.step = c; v.dwell = d; v.phase = ph; v.tri_m = t; v.npts = n;
    v.pts = '0;
    v.pts[0] = p0; v.pts[1] = p1; v.pts[2] = p2; v.pts[3] = p3;
    v.pts[4] = p4; v.pts[5] = p5; v.pts[6] = p6;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic offer(input vec_t v, input logic lp);
    bus.cfg_start_k = v.start;
    bus.cfg_stop_k = v.stop;
    bus.cfg_step_k = v.step;
    bus.cfg_dwell = v.dwell;
    bus.cfg_phase = v.phase;
    bus.cfg_loop = lp;
`ifdef DDS_SWEEP_TRIANGLE_EN
    bus.cfg_tri = v.tri_m;
`endif
    bus.cfg_valid = 1'b1;
  endtask

  task automatic run_sweep(input vec_t v, input string nm);
    int pulses = 0;
    bit done = 0;
    @(negedge clk);
    chk({nm, "_ready"}, bus.cfg_ready, 1);
    offer(v, 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      if (n > 1) @(negedge clk);
      if (k_valid) begin
        if (pulses < 8) chk({nm, "_k"}, k_out, v.pts[pulses]);
        chk({nm, "_kv_time"}, n, pulses * (v.dwell + 1) + 1);
        pulses++;
      end
      if (sweep_done) begin
        chk({nm, "_done_time"}, n, v.npts * (v.dwell + 1) + 1);
        chk({nm, "_busy_end"}, busy, 0);
        chk({nm, "_ready_end"}, bus.cfg_ready, 1);
        done = 1;
      end else if (busy !== 1'b1) begin
        chk({nm, "_busy"}, busy, 1);
      end
    end
    if (!done) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_pulses"}, pulses, v.npts);
    chk({nm, "_k_final"}, k_out, v.pts[v.npts-1]);
    chk({nm, "_p"}, p_out, v.phase);
  endtask

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_start_k = '0; bus.cfg_stop_k = '0; bus.cfg_step_k = '0;
    bus.cfg_dwell = '0; bus.cfg_phase = '0; bus.cfg_loop = 1'b0;
`ifdef DDS_SWEEP_TRIANGLE_EN
    bus.cfg_tri = 1'b0;
`endif
    tbl[0] = mk(100, 130, 10, 2, 11'h155, 0, 4, 100, 110, 120, 130, 0, 0, 0);
    tbl[1] = mk(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 11'h7FF, 0, 2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    tbl[2] = mk(500, 900, 0, 3, 11'h001, 0, 1, 500, 0, 0, 0, 0, 0, 0);
    tbl[3] = mk(900, 500, 7, 1, 11'h2AA, 0, 1, 900, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(0, 25, 10, 0, 11'h010, 0, 4, 0, 10, 20, 25, 0, 0, 0);
    tbl[5] = mk(42, 42, 5, 0, 11'h3C3, 0, 1, 42, 0, 0, 0, 0, 0, 0);
    v2 = mk(7, 9, 1, 0, 11'h077, 0, 3, 7, 8, 9, 0, 0, 0, 0);
    vt = mk(0, 30, 10, 0, 11'h123, 1, 7, 0, 10, 20, 30, 20, 10, 0);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_k", k_out, 0);
    chk("rst_p", p_out, 0);
    chk("rst_kv", k_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_ready", bus.cfg_ready, 1);

    for (int i = 0; i < 6; i++) run_sweep(tbl[i], $sformatf("vec%0d", i));
`ifdef DDS_SWEEP_TRIANGLE_EN
    run_sweep(vt, "tri");
`endif

    // continuous sweep, abort after the second wrap
    @(negedge clk);
    offer(tbl[0], 1'b1);
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
      chk($sformatf("loop_k%0d", n), k_out, lseq[((n - 1) / 3) % 4]);
      chk($sformatf("loop_done%0d", n), sweep_done, (n == 13 || n == 25) ? 1 : 0);
      chk($sformatf("loop_busy%0d", n), busy, 1);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("loop_abort_k", k_out, 0);
    chk("loop_abort_kv", k_valid, 1);
    chk("loop_abort_busy", busy, 0);
    chk("loop_abort_done", sweep_done, 0);
    chk("loop_abort_p", p_out, tbl[0].phase);
    repeat (4) begin
      @(negedge clk);
      chk("loop_post_done", sweep_done, 0);
      chk("loop_post_busy", busy, 0);
    end

    // abort mid-dwell with a competing cfg offer
    offer(tbl[0], 1'b0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      bus.cfg_valid = 1'b0;
    end
    chk("ab_k110", k_out, 110);
    chk("ab_ready_busy", bus.cfg_ready, 0);
    abort = 1'b1;
    offer(v2, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    chk("ab_k0", k_out, 0);
    chk("ab_kv", k_valid, 1);
    chk("ab_busy", busy, 0);
    chk("ab_done", sweep_done, 0);
    chk("ab_ready", bus.cfg_ready, 1);
    chk("ab_p_keep", p_out, tbl[0].phase);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    chk("ab_new_k", k_out, 7);
    chk("ab_new_busy", busy, 1);
    chk("ab_new_p", p_out, v2.phase);
    for (int n = 8; n <= 10; n++) begin
      @(negedge clk);
      if (n < 10) chk($sformatf("ab_new_k%0d", n), k_out, n);
      chk($sformatf("ab_new_done%0d", n), sweep_done, n == 10 ? 1 : 0);
    end

    // reset in the middle of a sweep
    @(negedge clk);
    offer(tbl[2], 1'b0);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    chk("rs_k500", k_out, 500);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_k", k_out, 0);
    chk("rs_p", p_out, 0);
    chk("rs_kv", k_valid, 0);
    chk("rs_busy", busy, 0);
    chk("rs_done", sweep_done, 0);
    chk("rs_ready", bus.cfg_ready, 1);
    repeat (8) begin
      @(negedge clk);
      chk("rs_post_done", sweep_done, 0);
      chk("rs_post_busy", busy, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
